// File: rtl/cone_bist_ctrl.sv
// cone_bist_ctrl: LFSR pattern source and MISR compactor that runs a BIST pass over an external combinational cone.
module cone_bist_ctrl #(
    parameter int N_IN = 14,
    parameter int N_OUT = 1,
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] LFSR_POLY = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    parameter int MISR_W = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'hB400,
    parameter int CNT_W = 16
) (
    input  logic              CK,
    input  logic              CLR,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  num_pat_i,
    input  logic [MISR_W-1:0] expect_i,
    input  logic [N_OUT-1:0]  resp_i,
    output logic [N_IN-1:0]   pat_o,
    output logic              pat_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [MISR_W-1:0] signature_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [LFSR_W-1:0] lfsr, lfsr_n;
    logic [MISR_W-1:0] misr, misr_n, exp_q, exp_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    always_ff @(posedge CK) begin
        if (CLR) begin
            state <= IDLE;
            lfsr  <= LFSR_SEED;
            misr  <= '0;
            cnt   <= '0;
            exp_q <= '0;
        end else begin
            state <= state_n;
            lfsr  <= lfsr_n;
            misr  <= misr_n;
            cnt   <= cnt_n;
            exp_q <= exp_n;
        end
    end
    // An abort freezes everything, so the signature keeps only fully absorbed patterns.
    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        misr_n  = misr;
        cnt_n   = cnt;
        exp_n   = exp_q;
        if (state == RUN) begin
            if (abort_i) begin
                state_n = IDLE;
            end else begin
                misr_n  = (misr >> 1) ^ (misr[0] ? MISR_POLY : '0) ^ MISR_W'(resp_i);
                lfsr_n  = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
                cnt_n   = cnt - 1'b1;
                state_n = (cnt == CNT_W'(1)) ? DONE : RUN;
            end
        end else if (start_i) begin
            exp_n   = expect_i;
            lfsr_n  = LFSR_SEED;
            misr_n  = '0;
            cnt_n   = num_pat_i;
            state_n = (|num_pat_i) ? RUN : DONE;
        end
    end
    assign pat_o       = lfsr[N_IN-1:0];
    assign busy_o      = state == RUN;
    assign pat_valid_o = state == RUN;
    assign done_o      = state == DONE;
    assign pass_o      = (state == DONE) && (misr == exp_q);
    assign signature_o = misr;
endmodule

// File: tb/tb_cone_bist_ctrl.sv
// tb_cone_bist_ctrl: randomized self-checking bench with a behavioural cone/LFSR/MISR reference model.
module tb_cone_bist_ctrl;
    logic CK = 0, CLR = 1, start_i = 0, abort_i = 0;
    logic [15:0] num_pat_i = 0, expect_i = 0, signature_o;
    logic [0:0] resp_i;
    logic [13:0] pat_o;
    logic pat_valid_o, busy_o, done_o, pass_o;
    int asserts = 0, fails = 0;
    int mode = 0;
    logic [13:0] exp_pats[$];

    cone_bist_ctrl dut (
        .CK(CK), .CLR(CLR), .start_i(start_i), .abort_i(abort_i), .num_pat_i(num_pat_i),
        .expect_i(expect_i), .resp_i(resp_i), .pat_o(pat_o), .pat_valid_o(pat_valid_o),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .signature_o(signature_o)
    );

    always #5 CK = ~CK;

    // Stand-in for the n55 cone: mode 0 healthy, 1 stuck-at-0, 2 stuck-at-1.
    function automatic logic cone(input logic [13:0] p);
        return ^(p & 14'h2A5B) ^ (p[3] & p[9]) ^ (p[0] | p[13]);
    endfunction

    always_comb resp_i = (mode == 0) ? cone(pat_o) : (mode == 2) ? 1'b1 : 1'b0;

    task automatic model(input int n, input int md, output logic [15:0] sig);
        logic [15:0] l, m;
        logic r;
        l = 16'hACE1;
        m = 0;
        exp_pats.delete();
        for (int k = 0; k < n; k++) begin
            exp_pats.push_back(l[13:0]);
            r = (md == 0) ? cone(l[13:0]) : (md == 2);
            m = (m >> 1) ^ (m[0] ? 16'hB400 : 16'h0) ^ {15'b0, r};
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0);
        end
        sig = m;
    endtask

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic start_run(input int n, input logic [15:0] e);
        start_i = 1;
        num_pat_i = 16'(n);
        expect_i = e;
        tick();
        start_i = 0;
    endtask

    task automatic do_run(input string name, input int n, input int md, input logic [15:0] e);
        logic [15:0] sig;
        model(n, md, sig);
        mode = md;
        start_run(n, e);
        for (int k = 0; k < n; k++) begin
            asserts++;
            if (pat_o !== exp_pats[k] || pat_valid_o !== 1'b1 || done_o !== 1'b0) begin
                fails++;
                $display("FAIL %s pat k=%0d: got pat=%h valid=%b done=%b, want pat=%h valid=1 done=0",
                         name, k + 1, pat_o, pat_valid_o, done_o, exp_pats[k]);
            end
            tick();
        end
        asserts++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || signature_o !== sig || pass_o !== (sig == e)) begin
            fails++;
            $display("FAIL %s end: got done=%b busy=%b sig=%h pass=%b, want done=1 busy=0 sig=%h pass=%b",
                     name, done_o, busy_o, signature_o, pass_o, sig, sig == e);
        end
    endtask

    task automatic test_reset;
        tick();
        tick();
        CLR = 0;
        asserts++;
        if (busy_o !== 0 || done_o !== 0 || pass_o !== 0 || pat_valid_o !== 0 || signature_o !== 0 || pat_o !== 14'h2CE1) begin
            fails++;
            $display("FAIL reset_init: got busy=%b done=%b pass=%b valid=%b sig=%h pat=%h, want 0 0 0 0 0000 2ce1",
                     busy_o, done_o, pass_o, pat_valid_o, signature_o, pat_o);
        end
        mode = 0;
        start_run(100, 16'h1234);
        repeat (5) tick();
        CLR = 1;
        tick();
        tick();
        CLR = 0;
        asserts++;
        if (busy_o !== 0 || done_o !== 0 || signature_o !== 0 || pat_o !== 14'h2CE1) begin
            fails++;
            $display("FAIL reset_midrun: got busy=%b done=%b sig=%h pat=%h, want 0 0 0000 2ce1",
                     busy_o, done_o, signature_o, pat_o);
        end
        repeat (3) begin
            tick();
            asserts++;
            if (done_o !== 0 || busy_o !== 0) begin
                fails++;
                $display("FAIL reset_after: got done=%b busy=%b, want 0 0", done_o, busy_o);
            end
        end
    endtask

    task automatic test_tied_one;
        mode = 2;
        start_run(2, 16'hB401);
        asserts++;
        if (pat_o !== 14'h2CE1 || busy_o !== 1 || signature_o !== 16'h0000) begin
            fails++;
            $display("FAIL tied_c1: got pat=%h busy=%b sig=%h, want 2ce1 1 0000", pat_o, busy_o, signature_o);
        end
        tick();
        asserts++;
        if (pat_o !== 14'h2270 || signature_o !== 16'h0001) begin
            fails++;
            $display("FAIL tied_c2: got pat=%h sig=%h, want 2270 0001", pat_o, signature_o);
        end
        tick();
        asserts++;
        if (done_o !== 1 || pass_o !== 1 || signature_o !== 16'hB401 || pat_valid_o !== 0) begin
            fails++;
            $display("FAIL tied_c3: got done=%b pass=%b sig=%h valid=%b, want 1 1 b401 0",
                     done_o, pass_o, signature_o, pat_valid_o);
        end
        tick();
        asserts++;
        if (done_o !== 1 || pass_o !== 1) begin
            fails++;
            $display("FAIL tied_hold: got done=%b pass=%b, want 1 1", done_o, pass_o);
        end
        start_run(2, 16'hB400);
        asserts++;
        if (done_o !== 0 || busy_o !== 1 || pat_o !== 14'h2CE1) begin
            fails++;
            $display("FAIL restart_c1: got done=%b busy=%b pat=%h, want 0 1 2ce1", done_o, busy_o, pat_o);
        end
        tick();
        tick();
        asserts++;
        if (done_o !== 1 || pass_o !== 0 || signature_o !== 16'hB401) begin
            fails++;
            $display("FAIL tied_badexp: got done=%b pass=%b sig=%h, want 1 0 b401", done_o, pass_o, signature_o);
        end
        do_run("tied_again", 2, 2, 16'hB401);
    endtask

    task automatic test_zero;
        bit seen_valid = 0;
        mode = 2;
        start_run(0, 16'h0000);
        seen_valid |= pat_valid_o;
        asserts++;
        if (done_o !== 1 || pass_o !== 1 || signature_o !== 0) begin
            fails++;
            $display("FAIL zero_pass: got done=%b pass=%b sig=%h, want 1 1 0000", done_o, pass_o, signature_o);
        end
        abort_i = 1;
        tick();
        abort_i = 0;
        seen_valid |= pat_valid_o;
        asserts++;
        if (done_o !== 1 || pass_o !== 1) begin
            fails++;
            $display("FAIL abort_in_done: got done=%b pass=%b, want 1 1", done_o, pass_o);
        end
        start_run(0, 16'h0001);
        seen_valid |= pat_valid_o;
        asserts++;
        if (done_o !== 1 || pass_o !== 0 || signature_o !== 0) begin
            fails++;
            $display("FAIL zero_fail: got done=%b pass=%b sig=%h, want 1 0 0000", done_o, pass_o, signature_o);
        end
        asserts++;
        if (seen_valid !== 0) begin
            fails++;
            $display("FAIL zero_valid: got pat_valid seen=%b, want 0", seen_valid);
        end
    endtask

    task automatic test_abort;
        mode = 2;
        start_run(10, 16'h0000);
        start_i = 1;
        num_pat_i = 3;
        tick();
        asserts++;
        if (busy_o !== 1 || signature_o !== 16'h0001 || pat_o !== 14'h2270) begin
            fails++;
            $display("FAIL abort_c2: got busy=%b sig=%h pat=%h, want 1 0001 2270", busy_o, signature_o, pat_o);
        end
        abort_i = 1;
        tick();
        start_i = 0;
        asserts++;
        if (busy_o !== 0 || done_o !== 0 || signature_o !== 16'h0001 || pat_o !== 14'h2270) begin
            fails++;
            $display("FAIL abort_c3: got busy=%b done=%b sig=%h pat=%h, want 0 0 0001 2270",
                     busy_o, done_o, signature_o, pat_o);
        end
        repeat (3) begin
            tick();
            asserts++;
            if (done_o !== 0 || busy_o !== 0 || signature_o !== 16'h0001) begin
                fails++;
                $display("FAIL abort_idle: got done=%b busy=%b sig=%h, want 0 0 0001", done_o, busy_o, signature_o);
            end
        end
        abort_i = 0;
    endtask

    task automatic test_random;
        logic [15:0] g;
        for (int i = 0; i < 8; i++) begin
            int n = $urandom_range(1, 300);
            int md = $urandom_range(0, 2);
            model(n, md, g);
            do_run("random", n, md, ($urandom_range(0, 1) == 1) ? g : g ^ 16'(1 << $urandom_range(0, 15)));
        end
    endtask

    task automatic test_cone;
        logic [15:0] g;
        model(1000, 0, g);
        do_run("cone_golden", 1000, 0, g);
        asserts++;
        if (pass_o !== 1) begin
            fails++;
            $display("FAIL cone_golden_pass: got pass=%b, want 1", pass_o);
        end
        do_run("cone_stuck0", 1000, 1, g);
        do_run("cone_stuck1", 1000, 2, g);
    endtask

    initial begin
        test_reset();
        test_tied_one();
        test_zero();
        test_abort();
        test_random();
        test_cone();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
